// File: rtl/pool_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : pool_writeback_if
//  Description : Window-input and memory-write handshake bundle for pool_writeback.
//  Revision    : 1.0  initial release
// ============================================================================
interface pool_writeback_if #(
    parameter int ADDR_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [0:3][7:0]       in_data;
    logic                  in_last;
    logic                  wr_en;
    logic                  wr_ready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [7:0]            wr_data;

    modport slave (
        input  in_valid, in_data, in_last, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data, in_last, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/pool_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : pool_writeback
//  Description : Threshold-ReLU + 2x2 max-pool of PE windows, FIFO-buffered
//                streaming to the output feature-map memory.
//  Revision    : 1.0  initial release
// ============================================================================
module pool_writeback #(
    parameter int ADDR_W    = 8,
    parameter int OUT_WORDS = 256,
    parameter int DEPTH     = 4,
    parameter int THRESH    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    pool_writeback_if.slave    bus,
    output logic [ADDR_W:0]    count,
    output logic               done
);

    localparam int                     c_ptr_w     = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]       c_depth     = (c_ptr_w+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]      c_last_addr = ADDR_W'(OUT_WORDS - 1);
    localparam logic [7:0]             c_thresh    = 8'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [7:0]            r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w:0]      r_fill;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [ADDR_W:0]       r_count;
    logic                  r_done;

    logic [7:0]            w_max01;
    logic [7:0]            w_max23;
    logic [7:0]            w_max;
    logic [8:0]            w_diff;
    logic [7:0]            w_pooled;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;

    assign w_max01  = (bus.in_data[0] > bus.in_data[1]) ? bus.in_data[0] : bus.in_data[1];
    assign w_max23  = (bus.in_data[2] > bus.in_data[3]) ? bus.in_data[2] : bus.in_data[3];
    assign w_max    = (w_max01 > w_max23) ? w_max01 : w_max23;
    // Borrow out of max-THRESH marks "below threshold" without a constant compare when THRESH is 0.
    assign w_diff   = {1'b0, w_max} - {1'b0, c_thresh};
    assign w_pooled = w_diff[8] ? 8'd0 : w_max;

    assign w_empty    = (r_fill == '0);
    assign w_full     = (r_fill == c_depth);
    assign w_in_ready = (r_state == S_RUN) && !w_full;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = !w_empty && bus.wr_ready;

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = !w_empty;
    assign bus.wr_data  = w_empty ? 8'd0 : r_mem[r_rd_ptr];
    assign bus.wr_addr  = r_wr_addr;
    assign count        = r_count;
    assign done         = r_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_pooled;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_wr_addr <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_w'(1);
                r_wr_addr <= (r_wr_addr == c_last_addr) ? '0 : r_wr_addr + ADDR_W'(1);
                if (r_count != '1) begin
                    r_count <= r_count + (ADDR_W+1)'(1);
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (c_ptr_w+1)'(1);
                2'b01:   r_fill <= r_fill - (c_ptr_w+1)'(1);
                default: r_fill <= r_fill;
            endcase

            // FIFO is always empty in IDLE/DONE, so the start clears cannot race a pop.
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_wr_addr <= '0;
                        r_count   <= '0;
                        r_done    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_push && bus.in_last) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
